// File: rtl/dm_responder.sv
// dm_responder: byte-addressed data-memory responder with a fixed access latency.
// A request accepted in IDLE waits LATENCY cycles in BUSY, is performed on the
// last BUSY edge, and is acknowledged by a one-cycle Mem_ready pulse in DONE.
// Words are big-endian: the byte at Mem_addr is the most significant byte.
// Optional feature macro: DM_MISALIGN_TRAP_EN. When it is defined, a request
// with Mem_addr[1:0] != 0 keeps the normal timing but performs no access and
// raises Mem_err alongside Mem_ready. When it is undefined, the low two address
// bits are forced to zero and the Mem_err port does not exist.
//
// Handshake: a request is a level on Mem_r/Mem_w. It is accepted only in IDLE.
// Mem_stall is high while the request is being accepted and while it is in
// BUSY. Mem_ready pulses for exactly one cycle when the access has completed,
// and the requester may present its next request in the following cycle.
module dm_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Mem_addr,
  input  logic [31:0] Mem_w_data,
  input  logic        Mem_w,
  input  logic        Mem_r,
  output logic [31:0] Mem_r_data,
  output logic        Mem_ready,
  output logic        Mem_stall,
`ifdef DM_MISALIGN_TRAP_EN
  output logic        Mem_err,
`endif
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]    LAT_M1 = 4'(LATENCY - 1);
  localparam logic [AW-1:0] IDX_1  = AW'(1);
  localparam logic [AW-1:0] IDX_2  = AW'(2);
  localparam logic [AW-1:0] IDX_3  = AW'(3);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_is_w;
  logic          r_mis;
  logic [31:0]   r_rdata;
  logic [7:0]    r_mem [DEPTH];

  logic          w_req;
  logic          w_mis;
  logic [AW-1:0] w_idx;
  logic          w_access;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;
  logic          w_unused;

  assign w_req = Mem_r | Mem_w;

`ifdef DM_MISALIGN_TRAP_EN
  // Misaligned requests are trapped instead of rounded down.
  assign w_mis = |Mem_addr[1:0];
  assign w_idx = Mem_addr[AW-1:0];
`else
  // Misaligned requests are silently aligned to the containing word.
  assign w_mis = 1'b0;
  assign w_idx = {Mem_addr[AW-1:2], 2'b00};
`endif

  // High address bits are ignored so accesses wrap around the array.
  assign w_unused = &{1'b0, Mem_addr[31:AW], Mem_addr[1:0]};

  // The captured access happens on the edge that ends the last BUSY cycle.
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0) && !r_mis;

  // Byte lanes of the captured word, wrapping modulo DEPTH.
  assign w_a1 = r_addr + IDX_1;
  assign w_a2 = r_addr + IDX_2;
  assign w_a3 = r_addr + IDX_3;

  // FSM, latency counter and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_is_w  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= BUSY;
            r_cnt   <= LAT_M1;
            r_addr  <= w_idx;
            r_wdata <= Mem_w_data;
            r_is_w  <= Mem_w;     // read+write together counts as a write
            r_mis   <= w_mis;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Read data register: loaded only by a completed read, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
    end else if (w_access && !r_is_w) begin
      r_rdata <= {r_mem[r_addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    end
  end

  // Storage array: no reset so contents survive rst_n; an aborted access
  // never reaches this edge because reset has already forced IDLE.
  always_ff @(posedge clk) begin
    if (w_access && r_is_w) begin
      r_mem[r_addr] <= r_wdata[31:24];
      r_mem[w_a1]   <= r_wdata[23:16];
      r_mem[w_a2]   <= r_wdata[15:8];
      r_mem[w_a3]   <= r_wdata[7:0];
    end
  end

  assign Mem_r_data  = r_rdata;
  assign Mem_ready   = (r_state == DONE);
  // Gated by rst_n so a request held during reset does not show a stall.
  assign Mem_stall   = rst_n && (((r_state == IDLE) && w_req) || (r_state == BUSY));
  assign o_dbg_state = r_state;

`ifdef DM_MISALIGN_TRAP_EN
  assign Mem_err = (r_state == DONE) && r_mis;
`endif

endmodule
